mem_data_dirty_dump: RTL and testbench

- Reader side of the data-memory dirty-bit tracking: on request, walks every data-memory address and checks the per-word dirty flag.
- Reads each dirty word from data memory and streams {address, data} to the debug unit over a valid/ready handshake.
- Sits between the data memory with its dirty-bit controller and the debug unit's transmit path. Used at end of program or at a breakpoint to dump only the modified memory.

---
 rtl/mem_data_dirty_dump.sv | 131 +++++++++++++
 tb/tb_mem_data_dirty_dump.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_data_dirty_dump.sv
// Dirty-word dump engine: scans data memory and streams modified words to debug.
// Optional macro DIRTY_CLEAR_ON_DUMP_EN enables the dirty-bit clear strobe.
//
// Ports:
//   i_clk, i_reset (async, active-low)   clock and reset
//   i_start                              one-cycle scan request (IDLE only)
//   o_addr, o_ena                        data-memory / dirty-flag address, read enable
//   i_bit_sucio, i_data                  dirty flag of o_addr, read data (1-cycle latency)
//   o_valid, i_ready                     dump handshake
//   o_tx_addr, o_tx_data                 dumped word
//   o_busy, o_done, o_count              status
//   o_clear_sucio                        dirty-bit clear strobe
module mem_data_dirty_dump #(
    parameter int RAM_DEPTH = 1024,
    parameter int RAM_WIDTH = 32,
    localparam int AW = $clog2(RAM_DEPTH)
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_start,
    output logic [AW-1:0]        o_addr,
    output logic                 o_ena,
    input  logic                 i_bit_sucio,
    input  logic [RAM_WIDTH-1:0] i_data,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [AW-1:0]        o_tx_addr,
    output logic [RAM_WIDTH-1:0] o_tx_data,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [AW:0]          o_count,
    output logic                 o_clear_sucio
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_READ,
        S_CAPTURE,
        S_SEND,
        S_DONE
    } state_t;

    localparam logic [AW-1:0] LAST = AW'(RAM_DEPTH - 1);

    state_t                state_q, state_d;
    logic [AW-1:0]         idx_q, idx_d;
    logic [AW:0]           count_q, count_d;
    logic [AW-1:0]         tx_addr_q;
    logic [RAM_WIDTH-1:0]  tx_data_q;
    logic                  handshake;

    assign handshake = (state_q == S_SEND) && i_ready;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            count_q   <= '0;
            tx_addr_q <= '0;
            tx_data_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            count_q <= count_d;
            if (state_q == S_CAPTURE) begin
                tx_addr_q <= idx_q;
                tx_data_q <= i_data;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        count_d = count_q;
        unique case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d = S_CHECK;
                    idx_d   = '0;
                    count_d = '0;
                end
            end
            S_CHECK: begin
                if (i_bit_sucio) begin
                    state_d = S_READ;
                end else if (idx_q == LAST) begin
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + AW'(1);
                end
            end
            S_READ:    state_d = S_CAPTURE;
            S_CAPTURE: state_d = S_SEND;
            S_SEND: begin
                if (i_ready) begin
                    count_d = count_q + (AW+1)'(1);
                    if (idx_q == LAST) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + AW'(1);
                        state_d = S_CHECK;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Status strobes decode straight from state so reset drops them at once.
    assign o_addr    = idx_q;
    assign o_ena     = (state_q == S_READ);
    assign o_valid   = (state_q == S_SEND);
    assign o_busy    = (state_q != S_IDLE);
    assign o_done    = (state_q == S_DONE);
    assign o_count   = count_q;
    assign o_tx_addr = tx_addr_q;
    assign o_tx_data = tx_data_q;

`ifdef DIRTY_CLEAR_ON_DUMP_EN
    // o_addr still points at the accepted word during the handshake cycle.
    assign o_clear_sucio = handshake;
`else
    logic unused_hs;
    assign unused_hs     = handshake;
    assign o_clear_sucio = 1'b0;
`endif

endmodule

// File: tb/tb_mem_data_dirty_dump.sv
// Testbench for mem_data_dirty_dump (RAM_DEPTH=16).
// Random memory/flags and ready patterns checked against a dump-list model.
module tb_mem_data_dirty_dump;
    localparam int D  = 16;
    localparam int AW = 4;

    logic          clk = 0;
    logic          rst_n = 0;
    logic          start = 0;
    logic [AW-1:0] addr;
    logic          ena;
    logic          sucio;
    logic [31:0]   rdata;
    logic          valid;
    logic          ready = 0;
    logic [AW-1:0] tx_addr;
    logic [31:0]   tx_data;
    logic          busy;
    logic          done;
    logic [AW:0]   count;
    logic          clr;

    mem_data_dirty_dump #(.RAM_DEPTH(D), .RAM_WIDTH(32)) dut (
        .i_clk(clk), .i_reset(rst_n), .i_start(start),
        .o_addr(addr), .o_ena(ena), .i_bit_sucio(sucio), .i_data(rdata),
        .o_valid(valid), .i_ready(ready), .o_tx_addr(tx_addr),
        .o_tx_data(tx_data), .o_busy(busy), .o_done(done),
        .o_count(count), .o_clear_sucio(clr)
    );

    always #5 clk = ~clk;

    // Environment: memory, dirty-bit controller
    logic [31:0]  mem [D];
    logic [D-1:0] dirty_set = '0;
    logic [D-1:0] cleared = '0;
    logic         env_clr = 0;
    assign sucio = dirty_set[addr] & ~cleared[addr];

    always @(posedge clk) begin
        if (ena) rdata <= mem[addr];
        if (env_clr) cleared <= '0;
        else if (clr) cleared[addr] <= 1'b1;
    end

    // Monitor
    int cyc = 0;
    int done_cnt, busy_cnt, valid_cnt, hs_cyc, done_cyc;
    logic [35:0]   hs_q[$];
    logic [AW-1:0] clr_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid && ready) begin
            hs_q.push_back({tx_addr, tx_data});
            hs_cyc = cyc;
        end
        if (clr) clr_q.push_back(addr);
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (busy) busy_cnt++;
        if (valid) valid_cnt++;
    end

    // Reference model: a scan dumps every dirty word in ascending order
    logic [D-1:0] mdirty;
    logic [35:0]  exp_q[$];
    int checks = 0;
    int failures = 0;

    function automatic void build_exp();
        exp_q.delete();
        for (int a = 0; a < D; a++)
            if (mdirty[a]) exp_q.push_back({4'(a), mem[a]});
    endfunction

    function automatic void model_after_scan();
`ifdef DIRTY_CLEAR_ON_DUMP_EN
        mdirty = '0;
`endif
    endfunction

    task automatic setup(input logic [D-1:0] flags, input bit rnd);
        for (int a = 0; a < D; a++)
            mem[a] = rnd ? $urandom : 32'h1000_0000 + a;
        dirty_set = flags;
        mdirty    = flags;
        @(posedge clk); #1 env_clr = 1;
        @(posedge clk); #1 env_clr = 0;
    endtask

    task automatic clear_mon();
        hs_q.delete();
        clr_q.delete();
        done_cnt = 0; busy_cnt = 0; valid_cnt = 0;
        hs_cyc = 0; done_cyc = 0;
    endtask

    task automatic run_scan(input bit rnd_ready, input bit mid_start);
        int n;
        clear_mon();
        build_exp();
        start = 1;
        @(posedge clk); #1 start = 0;
        n = 0;
        while (done_cnt == 0 && n < 2000) begin
            ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            start = (mid_start && n == 8);
            @(posedge clk); #1;
            n++;
        end
        start = 0; ready = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (done_cnt == 0) begin
            failures++;
            $display("FAIL scan_timeout done_cnt=%0d exp>0", done_cnt);
        end
        model_after_scan();
    endtask

    task automatic cmp_dump(input string nm);
        checks++;
        if (hs_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL %s_len got=%0d exp=%0d", nm, hs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < hs_q.size(); i++) begin
            checks++;
            if (hs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL %s_word%0d got=%h exp=%h", nm, i, hs_q[i], exp_q[i]);
            end
        end
        checks++;
        if (count !== (AW+1)'(exp_q.size())) begin
            failures++;
            $display("FAIL %s_count got=%0d exp=%0d", nm, count, exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 0;
        #12;
        checks++;
        if ({addr, ena, valid, busy, done, clr} !== '0) begin
            failures++;
            $display("FAIL reset_ctl got=%b exp=0", {addr, ena, valid, busy, done, clr});
        end
        checks++;
        if ({tx_addr, tx_data, count} !== '0) begin
            failures++;
            $display("FAIL reset_data got=%h exp=0", {tx_addr, tx_data, count});
        end
        @(posedge clk); #1 rst_n = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_all_clean();
        setup('0, 1);
        run_scan(0, 0);
        checks++;
        if (busy_cnt !== 17) begin
            failures++;
            $display("FAIL clean_busy got=%0d exp=17", busy_cnt);
        end
        checks++;
        if (done_cnt !== 1) begin
            failures++;
            $display("FAIL clean_done got=%0d exp=1", done_cnt);
        end
        checks++;
        if (valid_cnt !== 0) begin
            failures++;
            $display("FAIL clean_valid got=%0d exp=0", valid_cnt);
        end
        cmp_dump("clean");
    endtask

    task automatic test_two_words();
        setup(16'h8008, 0);
        mem[3] = 32'hDEADBEEF; mem[15] = 32'h12345678;
        run_scan(0, 0);
        cmp_dump("two");
        checks++;
        if (!(done_cyc > hs_cyc)) begin
            failures++;
            $display("FAIL two_done_order got=%0d exp>%0d", done_cyc, hs_cyc);
        end
    endtask

    task automatic test_stall();
        int n;
        setup(16'h8008, 0);
        mem[3] = 32'hDEADBEEF; mem[15] = 32'h12345678;
        clear_mon();
        build_exp();
        ready = 0;
        start = 1;
        @(posedge clk); #1 start = 0;
        n = 0;
        while (!valid && n < 100) begin
            @(posedge clk); #1; n++;
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (valid !== 1'b1 || tx_addr !== 4'd3 || tx_data !== 32'hDEADBEEF) begin
                failures++;
                $display("FAIL stall_hold%0d got=%b/%0d/%h exp=1/3/deadbeef",
                         k, valid, tx_addr, tx_data);
            end
        end
        @(posedge clk); #1 ready = 1;
        n = 0;
        while (done_cnt == 0 && n < 200) begin
            @(posedge clk); #1; n++;
        end
        ready = 0;
        @(posedge clk); #1;
        model_after_scan();
        cmp_dump("stall");
    endtask

    task automatic test_all_dirty();
        setup('1, 1);
        run_scan(0, 1);
        cmp_dump("alldirty");
        checks++;
        if (done_cnt !== 1) begin
            failures++;
            $display("FAIL alldirty_done got=%0d exp=1", done_cnt);
        end
    endtask

    task automatic test_reset_mid_send();
        int n;
        setup(16'h8008, 1);
        clear_mon();
        ready = 0;
        start = 1;
        @(posedge clk); #1 start = 0;
        n = 0;
        while (!valid && n < 100) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (valid !== 1'b1 || tx_addr !== 4'd3) begin
            failures++;
            $display("FAIL rstmid_send got=%b/%0d exp=1/3", valid, tx_addr);
        end
        #2 rst_n = 0;
        #1;
        checks++;
        if ({valid, busy, count} !== '0) begin
            failures++;
            $display("FAIL rstmid_drop got=%b exp=0", {valid, busy, count});
        end
        @(posedge clk); #1 rst_n = 1;
        checks++;
        if (addr !== 4'd0) begin
            failures++;
            $display("FAIL rstmid_addr got=%0d exp=0", addr);
        end
        run_scan(0, 0);
        cmp_dump("rstmid");
    endtask

    task automatic test_clear_two_scans();
        logic [AW-1:0] exp_clr[$];
        setup(16'h8008, 1);
        run_scan(1, 0);
        cmp_dump("clr1");
`ifdef DIRTY_CLEAR_ON_DUMP_EN
        exp_clr = '{4'd3, 4'd15};
`endif
        checks++;
        if (clr_q != exp_clr) begin
            failures++;
            $display("FAIL clr_strobes got=%p exp=%p", clr_q, exp_clr);
        end
        run_scan(1, 0);
        cmp_dump("clr2");
    endtask

    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            setup(D'($urandom), 1);
            run_scan(1, 0);
            cmp_dump($sformatf("rnd%0d_a", it));
            run_scan(1, 0);
            cmp_dump($sformatf("rnd%0d_b", it));
        end
    endtask

    initial begin
        test_reset();
        test_all_clean();
        test_two_words();
        test_stall();
        test_all_dirty();
        test_reset_mid_send();
        test_clear_two_scans();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
